rx_word_checker: RTL and testbench

//  Receive-side stage directly downstream of the channel. Accepts 10-bit codewords

---
 rtl/rx_word_checker.sv | 124 ++++++++++++
 tb/tb_rx_word_checker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_word_checker.sv
// Parity-checking receive stage: recomputes 3 parity bits over 7 data bits and
// queues {data, err} in a show-ahead FIFO. Optional error counter: RX_WORD_CHECKER_ERR_CNT_EN.
module rx_word_checker #(
    parameter int DEPTH    = 4,
    parameter bit DROP_BAD = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [9:0]               in_code,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [6:0]               out_data,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   level
`ifdef RX_WORD_CHECKER_ERR_CNT_EN
    ,
    output logic [7:0]               err_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [6:0]    d;
    logic [2:0]    p_calc;
    logic [2:0]    syndrome;
    logic          err;
    logic          accept;
    logic          wr_en;
    logic          pop;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;

    assign d = in_code[6:0];

    // Even parity over fixed data-bit subsets
    assign p_calc[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    assign p_calc[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    assign p_calc[2] = d[1] ^ d[2] ^ d[3];

    assign syndrome = p_calc ^ in_code[9:7];
    assign err      = |syndrome;

    assign in_ready  = (level_q != LW'(DEPTH));
    assign out_valid = (level_q != '0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign wr_en     = accept & ~(DROP_BAD & err);

    assign out_data = mem_q[rd_ptr_q][7:1];
    assign out_err  = mem_q[rd_ptr_q][0];
    assign level    = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({wr_en, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is cleared on reset so the show-ahead outputs read zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= {d, err};
        end
    end

`ifdef RX_WORD_CHECKER_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    logic [7:0] err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_rx_word_checker.sv
// Scoreboard bench for rx_word_checker: directed codewords with hand-computed
// data/err; a negedge monitor pops expected entries on every output handshake.
module tb_rx_word_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] in_code = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [6:0] out_data;
    logic       out_err;
    logic [2:0] level;

    logic       d_in_ready;
    logic       d_out_valid;
    logic       d_out_ready = 1'b0;
    logic [6:0] d_out_data;
    logic       d_out_err;
    logic [2:0] d_level;

`ifdef RX_WORD_CHECKER_ERR_CNT_EN
    logic [7:0] err_count;
    logic [7:0] d_err_count;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    rx_word_checker #(.DEPTH(4), .DROP_BAD(1'b0)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .level(level)
`ifdef RX_WORD_CHECKER_ERR_CNT_EN
        , .err_count(err_count)
`endif
    );

    rx_word_checker #(.DEPTH(4), .DROP_BAD(1'b1)) u_drop (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(d_in_ready), .in_code(in_code),
        .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_data(d_out_data), .out_err(d_out_err), .level(d_level)
`ifdef RX_WORD_CHECKER_ERR_CNT_EN
        , .err_count(d_err_count)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic push(input logic [9:0] c, input logic [6:0] ed,
                        input logic ee);
        int n = 0;
        in_valid = 1'b1;
        in_code = c;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout: code %0h never accepted", c);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back({ed, ee});
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        out_ready = 1'b0;
        chk("drain_done", 32'(exp_q.size()), 32'd0);
        chk("drain_level", 32'(level), 32'd0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
    endtask

    // Monitor: compare the head entry on every output handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_unexpected: got %0h/%0b, expected nothing",
                         out_data, out_err);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                vectors++;
                if (out_data !== e[7:1] || out_err !== e[0]) begin
                    miscompares++;
                    $display("FAIL sb_entry: got %0h/%0b, expected %0h/%0b",
                             out_data, out_err, e[7:1], e[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
`ifdef RX_WORD_CHECKER_ERR_CNT_EN
        chk("rst_err_count", 32'(err_count), 32'd0);
`endif

        push(10'h3D5, 7'h55, 1'b0);
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        chk("lat_out_data", 32'(out_data), 32'h55);
        chk("lat_out_err", 32'(out_err), 32'd0);
        chk("lat_level", 32'(level), 32'd1);
        chk("drop_good_level", 32'(d_level), 32'd1);

        push(10'h3D4, 7'h54, 1'b1);
        chk("bad_level", 32'(level), 32'd2);
        chk("drop_bad_level", 32'(d_level), 32'd1);
        chk("drop_head_data", 32'(d_out_data), 32'h55);
        chk("drop_head_err", 32'(d_out_err), 32'd0);
`ifdef RX_WORD_CHECKER_ERR_CNT_EN
        chk("err_count_1", 32'(err_count), 32'd1);
        chk("drop_err_count_1", 32'(d_err_count), 32'd1);
`endif
        drain();

        do_reset();
        chk("drop_rst_level", 32'(d_level), 32'd0);

        push(10'h000, 7'h00, 1'b0);
        push(10'h3FF, 7'h7F, 1'b0);
        push(10'h02A, 7'h2A, 1'b0);
        push(10'h181, 7'h01, 1'b0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_level", 32'(level), 32'd4);
        in_valid = 1'b1;
        in_code = 10'h388;
        step();
        chk("held_in_ready", 32'(in_ready), 32'd0);
        chk("held_level", 32'(level), 32'd4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("after_pop_in_ready", 32'(in_ready), 32'd1);
        chk("after_pop_level", 32'(level), 32'd3);
        @(posedge clk);
        exp_q.push_back({7'h08, 1'b0});
        #1;
        in_valid = 1'b0;
        chk("fifth_level", 32'(level), 32'd4);
        drain();

        push(10'h3D5, 7'h55, 1'b0);
        push(10'h02A, 7'h2A, 1'b0);
        chk("pp_pre_level", 32'(level), 32'd2);
        out_ready = 1'b1;
        push(10'h3FF, 7'h7F, 1'b0);
        out_ready = 1'b0;
        chk("pp_level", 32'(level), 32'd2);
        drain();

        out_ready = 1'b1;
        push(10'h000, 7'h00, 1'b0);
        push(10'h080, 7'h00, 1'b1);
        push(10'h181, 7'h01, 1'b0);
        push(10'h388, 7'h08, 1'b0);
        push(10'h3D4, 7'h54, 1'b1);
        push(10'h3FF, 7'h7F, 1'b0);
        drain();

        push(10'h3FF, 7'h7F, 1'b0);
        push(10'h000, 7'h00, 1'b0);
        push(10'h02A, 7'h2A, 1'b0);
        chk("pre_rst_level", 32'(level), 32'd3);
        rst = 1'b1;
        step();
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        exp_q.delete();
        push(10'h3D5, 7'h55, 1'b0);
        chk("post_rst_out_valid", 32'(out_valid), 32'd1);
        chk("post_rst_out_data", 32'(out_data), 32'h55);
        chk("post_rst_level", 32'(level), 32'd1);
        drain();

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
